// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback scheduler slice.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; a tie goes to whoever did not win last.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_alu,
  input  logic req_mem,
  output logic grant_alu,
  output logic grant_mem
);

  grant_e last_grant, last_grant_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_MEM;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    grant_alu       = 1'b0;
    grant_mem       = 1'b0;
    last_grant_next = last_grant;
    if (!rst) begin
      unique case ({req_alu, req_mem})
        2'b10:   grant_alu = 1'b1;
        2'b01:   grant_mem = 1'b1;
        2'b11: begin
          if (last_grant == GRANT_MEM) grant_alu = 1'b1;
          else                         grant_mem = 1'b1;
        end
        default: ;
      endcase
      if (grant_alu) last_grant_next = GRANT_ALU;
      if (grant_mem) last_grant_next = GRANT_MEM;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port scheduler and busy-register scoreboard in front of the 32x32
// register file: arbitrates ALU/MEM writebacks and stalls issue on RAW/WAW.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iIssueValid,
  input  logic [ADDR_WIDTH-1:0] iRs1,
  input  logic                  iRs1En,
  input  logic [ADDR_WIDTH-1:0] iRs2,
  input  logic                  iRs2En,
  input  logic [ADDR_WIDTH-1:0] iRd,
  input  logic                  iRdEn,
  output logic                  oStall,
  input  logic                  iAluValid,
  input  logic [ADDR_WIDTH-1:0] iAluAddr,
  input  logic [DATA_WIDTH-1:0] iAluData,
  output logic                  oAluAck,
  input  logic                  iMemValid,
  input  logic [ADDR_WIDTH-1:0] iMemAddr,
  input  logic [DATA_WIDTH-1:0] iMemData,
  output logic                  oMemAck,
  output logic                  oWe,
  output logic [ADDR_WIDTH-1:0] oWAddr,
  output logic [DATA_WIDTH-1:0] oWData,
  output logic [ADDR_WIDTH:0]   oPendingCnt,
  output logic                  oWbErr
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [NUM_REGS-1:0]   busy, busy_next;
  logic [ADDR_WIDTH:0]   cnt_next;
  logic                  grant_alu, grant_mem;
  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  issue_fire;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (reset),
    .req_alu   (iAluValid),
    .req_mem   (iMemValid),
    .grant_alu (grant_alu),
    .grant_mem (grant_mem)
  );

  assign oAluAck  = grant_alu;
  assign oMemAck  = grant_mem;
  assign wb_valid = grant_alu | grant_mem;
  assign wb_addr  = grant_mem ? iMemAddr : iAluAddr;
  assign wb_data  = grant_mem ? iMemData : iAluData;

  always_comb begin
    oStall = 1'b0;
    if (!reset && iIssueValid) begin
      oStall = (iRs1En && busy[iRs1]) ||
               (iRs2En && busy[iRs2]) ||
               (iRdEn  && busy[iRd]);
    end
  end

  assign issue_fire = iIssueValid & ~oStall;

  // Clear from the write landing this cycle, then set from issue so set wins.
  always_comb begin
    busy_next = busy;
    if (oWe) busy_next[oWAddr] = 1'b0;
    if (issue_fire && iRdEn && (iRd != ZERO_ADDR)) busy_next[iRd] = 1'b1;
    busy_next[REG_ZERO] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_next = cnt_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= '0;
      oWe         <= 1'b0;
      oWAddr      <= '0;
      oWData      <= '0;
      oPendingCnt <= '0;
      oWbErr      <= 1'b0;
    end else begin
      busy        <= busy_next;
      oPendingCnt <= cnt_next;
      oWe         <= wb_valid && (wb_addr != ZERO_ADDR);
      if (wb_valid) begin
        oWAddr <= wb_addr;
        oWData <= wb_data;
        if ((wb_addr != ZERO_ADDR) && !busy[wb_addr]) oWbErr <= 1'b1;
      end
    end
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Write-port scheduler and hazard scoreboard for the 32x32 decode-stage register file (one write port, two combinational read ports).
- Arbitrates the single write port between two writeback requesters: ALU and MEM (load).
- Tracks pending destination registers and stalls issue on RAW/WAW hazards, so decode never reads stale data. There is no forwarding path.
- Sits between decode/issue and registerFile. It drives iWAddr/iWData/we of the register file.

Parameters:
DATA_WIDTH, 32, register/data width
ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
iIssueValid  in  1  decode presents an instruction this cycle
iRs1  in  ADDR_WIDTH  source 1 address
iRs1En  in  1  source 1 is used
iRs2  in  ADDR_WIDTH  source 2 address
iRs2En  in  1  source 2 is used
iRd  in  ADDR_WIDTH  destination address
iRdEn  in  1  instruction writes iRd
oStall  out  1  issue blocked this cycle (combinational)
iAluValid  in  1  ALU writeback request
iAluAddr  in  ADDR_WIDTH  ALU destination
iAluData  in  DATA_WIDTH  ALU result
oAluAck  out  1  ALU request accepted this cycle (combinational)
iMemValid  in  1  MEM writeback request
iMemAddr  in  ADDR_WIDTH  MEM destination
iMemData  in  DATA_WIDTH  load data
oMemAck  out  1  MEM request accepted this cycle (combinational)
oWe  out  1  register file write enable (registered)
oWAddr  out  ADDR_WIDTH  register file write address (registered)
oWData  out  DATA_WIDTH  register file write data (registered)
oPendingCnt  out  ADDR_WIDTH+1  number of busy registers (registered)
oWbErr  out  1  sticky: writeback to a non-busy register

Behaviour:
- Reset (async):
  - busy[] = 0; oWe = 0; oWAddr = 0; oWData = 0; oPendingCnt = 0; oWbErr = 0; lastGrant = MEM.
  - While reset is high, oAluAck = oMemAck = 0 and oStall = 0.
- Scoreboard: busy[NUM_REGS-1:0]. busy[0] is never set.
- oStall = iIssueValid & ((iRs1En & busy[iRs1]) | (iRs2En & busy[iRs2]) | (iRdEn & busy[iRd])).
  - RAW and WAW are covered; register 0 is never busy.
- Issue accepted when iIssueValid & !oStall. If iRdEn and iRd != 0, busy[iRd] is set at that edge.
- Handshake: a requester holds valid/addr/data stable until it sees ack high in the same cycle. Ack completes the transfer at that edge.
- Arbitration, one grant per cycle:
  - Only one valid: grant it.
  - Both valid: round-robin. Grant the requester not equal to lastGrant.
  - lastGrant updates to the winner on every grant. After reset the ALU wins the first tie.
- Latency:
  - Grant in cycle N -> oWe/oWAddr/oWData valid in cycle N+1.
  - The register file captures at the end of N+1.
  - busy[addr] clears on that same end-of-N+1 edge.
  - Decode sees the new value and no stall from cycle N+2.
- oWe deasserts in any cycle with no grant. oWAddr/oWData hold their last value.
- Address 0 writeback: acked normally, oWe stays 0, no busy change.
- Grant to a non-busy address (nonzero): the write still proceeds, and oWbErr sets and stays set until reset.
- Set/clear same register on the same edge: set wins. This cannot occur through legal issue because WAW stalls; it is defined for robustness.
- oPendingCnt: registered popcount of the next busy state. It is 0..NUM_REGS-1 and never counts register 0.
- Reset mid-operation:
  - In-flight requests are dropped with no ack, and pending oWe is cleared.
  - Requesters re-present after reset.

Decomposition:
- Shared package (regfile_pkg) holds:
  - DATA_WIDTH/ADDR_WIDTH defaults;
  - the requester ID encoding, GRANT_ALU = 1'b0 and GRANT_MEM = 1'b1;
  - the REG_ZERO constant.
- One natural sub-module: rr_arbiter2 (2-requester round-robin with lastGrant state).
- The scoreboard and output register stay in the top.

Test Plan:
- Reset then issue rd=2 (rs unused) -> busy[2]=1, oPendingCnt=1. A next-cycle issue with rs1=2 gives oStall=1. ALU writes addr 2, data 0x1 (ack cycle N) -> oWe=1, oWAddr=2, oWData=1 in N+1; oStall=0 in N+2; oPendingCnt=0.
- Set busy[1] and busy[2]. ALU(addr1, 0x2) and MEM(addr2, 0x5) are valid together for 2 cycles:
  - cycle 1: oAluAck=1, oMemAck=0;
  - cycle 2: oMemAck=1;
  - oWe sequence: addr1/0x2 then addr2/0x5.
- Issue rd=0 -> no busy set, oPendingCnt=0. ALU writeback to addr 0 -> oAluAck=1, oWe stays 0, oWbErr=0.
- MEM writeback to addr 7 with busy[7]=0 -> oMemAck=1, oWe=1 next cycle, oWbErr=1 and held until reset.
- Issue rd=3 then, while busy[3]=1, issue rd=3 again (WAW) -> oStall=1 until the cycle after the write to 3 lands; then accepted and busy[3]=1 again.
- Assert reset with busy[4]=1 and ALU valid -> immediately oAluAck=0, oWe=0, oPendingCnt=0, oStall=0. After release the first tie grants ALU.
